// File: rtl/st2110_rtp_scheduler.sv
// Round-robin scheduler that packs one video and one audio source into a single
// RTP word stream: three header words (V/P/X/CC/M/PT/seq, timestamp, SSRC) then payload.
module st2110_rtp_scheduler #(
    parameter int unsigned VID_WORDS = 360,
    parameter int unsigned AUD_WORDS = 48,
    parameter logic [6:0]  VID_PT    = 7'd96,
    parameter logic [6:0]  AUD_PT    = 7'd97,
    parameter logic [31:0] VID_SSRC  = 32'h0000_1110,
    parameter logic [31:0] AUD_SSRC  = 32'h0000_2110
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        vid_req,
    input  logic        aud_req,
    input  logic [31:0] vid_ts,
    input  logic [31:0] aud_ts,
    input  logic        vid_marker,
    input  logic        aud_marker,
    input  logic [31:0] vid_data,
    input  logic [31:0] aud_data,
    output logic        vid_rd,
    output logic        aud_rd,
    output logic [31:0] out_data,
    output logic        out_valid,
    output logic        out_sop,
    output logic        out_eop,
    input  logic        out_ready,
    output logic        busy,
    output logic [2:0]  dbg_state
);

    localparam int unsigned MAXW = (VID_WORDS > AUD_WORDS) ? VID_WORDS : AUD_WORDS;
    localparam int CW = $clog2(MAXW + 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HDR0 = 3'd1,
        S_HDR1 = 3'd2,
        S_HDR2 = 3'd3,
        S_PAY  = 3'd4
    } state_t;

    state_t        r_state;
    logic          r_sel_aud;
    logic          r_last_aud;
    logic          r_marker;
    logic [6:0]    r_pt;
    logic [15:0]   r_seq;
    logic [31:0]   r_ts;
    logic [31:0]   r_ssrc;
    logic [15:0]   r_vid_seq;
    logic [15:0]   r_aud_seq;
    logic [CW-1:0] r_cnt;
    logic          r_valid;
    logic          r_sop;
    logic          r_eop;
    logic          r_busy;

    logic          w_grant;
    logic          w_pick_aud;
    logic          w_accept;
    logic          w_last_word;

    // Handshake: a word transfers on a rising edge where out_valid && out_ready;
    // out_valid never drops and out_data never changes until that transfer happens.
    assign w_accept    = r_valid && out_ready;
    assign w_grant     = en && (vid_req || aud_req);
    // r_last_aud == 0 after reset, so audio wins the first tie.
    assign w_pick_aud  = aud_req && (!vid_req || !r_last_aud);
    assign w_last_word = (r_cnt == CW'(1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_sel_aud  <= 1'b0;
            r_last_aud <= 1'b0;
            r_marker   <= 1'b0;
            r_pt       <= 7'd0;
            r_seq      <= 16'd0;
            r_ts       <= 32'd0;
            r_ssrc     <= 32'd0;
            r_vid_seq  <= 16'd0;
            r_aud_seq  <= 16'd0;
            r_cnt      <= '0;
            r_valid    <= 1'b0;
            r_sop      <= 1'b0;
            r_eop      <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_grant) begin
                        r_state    <= S_HDR0;
                        r_sel_aud  <= w_pick_aud;
                        r_last_aud <= w_pick_aud;
                        r_marker   <= w_pick_aud ? aud_marker : vid_marker;
                        r_pt       <= w_pick_aud ? AUD_PT : VID_PT;
                        r_seq      <= w_pick_aud ? r_aud_seq : r_vid_seq;
                        r_ts       <= w_pick_aud ? aud_ts : vid_ts;
                        r_ssrc     <= w_pick_aud ? AUD_SSRC : VID_SSRC;
                        r_cnt      <= w_pick_aud ? CW'(AUD_WORDS) : CW'(VID_WORDS);
                        r_valid    <= 1'b1;
                        r_sop      <= 1'b1;
                        r_busy     <= 1'b1;
                    end
                end
                S_HDR0: begin
                    if (w_accept) begin
                        r_state <= S_HDR1;
                        r_sop   <= 1'b0;
                    end
                end
                S_HDR1: begin
                    if (w_accept) begin
                        r_state <= S_HDR2;
                    end
                end
                S_HDR2: begin
                    if (w_accept) begin
                        r_state <= S_PAY;
                        r_eop   <= w_last_word;
                    end
                end
                S_PAY: begin
                    if (w_accept) begin
                        if (w_last_word) begin
                            r_state <= S_IDLE;
                            r_valid <= 1'b0;
                            r_eop   <= 1'b0;
                            r_busy  <= 1'b0;
                            if (r_sel_aud) begin
                                r_aud_seq <= r_aud_seq + 16'd1;
                            end else begin
                                r_vid_seq <= r_vid_seq + 16'd1;
                            end
                        end else begin
                            r_cnt <= r_cnt - CW'(1);
                            r_eop <= (r_cnt == CW'(2));
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_valid <= 1'b0;
                    r_sop   <= 1'b0;
                    r_eop   <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Payload words come straight from the source head so no buffering is needed.
    always_comb begin
        out_data = 32'd0;
        unique case (r_state)
            S_HDR0:  out_data = {2'b10, 1'b0, 1'b0, 4'h0, r_marker, r_pt, r_seq};
            S_HDR1:  out_data = r_ts;
            S_HDR2:  out_data = r_ssrc;
            S_PAY:   out_data = r_sel_aud ? aud_data : vid_data;
            default: out_data = 32'd0;
        endcase
    end

    assign vid_rd    = (r_state == S_PAY) && !r_sel_aud && out_ready;
    assign aud_rd    = (r_state == S_PAY) &&  r_sel_aud && out_ready;
    assign out_valid = r_valid;
    assign out_sop   = r_sop;
    assign out_eop   = r_eop;
    assign busy      = r_busy;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_st2110_rtp_scheduler.sv
// Directed bench for st2110_rtp_scheduler with VID_WORDS=4, AUD_WORDS=2; sources are
// modelled as FWFT counters so every payload word is predictable.
module tb_st2110_rtp_scheduler;

  localparam int unsigned VW = 4;
  localparam int unsigned AW = 2;
  localparam logic [31:0] VID_BASE = 32'hA000_0000;
  localparam logic [31:0] AUD_BASE = 32'hB000_0000;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        vid_req, aud_req;
  logic [31:0] vid_ts, aud_ts;
  logic        vid_marker, aud_marker;
  logic [31:0] vid_data, aud_data;
  logic        vid_rd, aud_rd;
  logic [31:0] out_data;
  logic        out_valid, out_sop, out_eop;
  logic        out_ready;
  logic        busy;
  logic [2:0]  dbg_state;

  st2110_rtp_scheduler #(
    .VID_WORDS(VW),
    .AUD_WORDS(AW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .vid_req(vid_req), .aud_req(aud_req),
    .vid_ts(vid_ts), .aud_ts(aud_ts),
    .vid_marker(vid_marker), .aud_marker(aud_marker),
    .vid_data(vid_data), .aud_data(aud_data),
    .vid_rd(vid_rd), .aud_rd(aud_rd),
    .out_data(out_data), .out_valid(out_valid), .out_sop(out_sop), .out_eop(out_eop),
    .out_ready(out_ready), .busy(busy), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // source model: head word is base + number of words popped so far
  int vid_idx = 0;
  int aud_idx = 0;
  always @(posedge clk) begin
    if (vid_rd) vid_idx <= vid_idx + 1;
    if (aud_rd) aud_idx <= aud_idx + 1;
  end
  assign vid_data = VID_BASE + 32'(vid_idx);
  assign aud_data = AUD_BASE + 32'(aud_idx);

  // scoreboard state
  int n_checks = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];
  logic [15:0] exp_vid_seq = 16'd0;
  logic [15:0] exp_aud_seq = 16'd0;
  logic [31:0] cap_data[$];
  bit          cap_sop[$];
  bit          cap_eop[$];
  int          cap_vid_rd, cap_aud_rd, stall_err, rd_err;
  bit          cap_timeout;

  function automatic void build_exp(input bit is_aud, input bit mk, input logic [15:0] seq,
                                    input logic [31:0] ts, input int start);
    logic [6:0] pt;
    pt = is_aud ? 7'd97 : 7'd96;
    exp_q.delete();
    exp_q.push_back({2'b10, 1'b0, 1'b0, 4'h0, mk, pt, seq});
    exp_q.push_back(ts);
    exp_q.push_back(is_aud ? 32'h0000_2110 : 32'h0000_1110);
    for (int k = 0; k < int'(is_aud ? AW : VW); k++)
      exp_q.push_back((is_aud ? AUD_BASE : VID_BASE) + 32'(start + k));
  endfunction

  // driver: hold out_ready low until the DUT leaves IDLE
  task automatic wait_grant(output bit tmo);
    tmo = 1'b1;
    out_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      if (busy) begin
        tmo = 1'b0;
        break;
      end
    end
  endtask

  // driver/monitor: accept words until eop, recording stalls and rd pulses
  task automatic capture_pkt(input bit rand_ready);
    bit done, held;
    logic [31:0] held_data;
    cap_data.delete(); cap_sop.delete(); cap_eop.delete();
    cap_vid_rd = 0; cap_aud_rd = 0; stall_err = 0; rd_err = 0;
    done = 1'b0; held = 1'b0; held_data = '0;
    for (int n = 0; n < 300 && !done; n++) begin
      @(negedge clk);
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (held && (!out_valid || out_data !== held_data)) stall_err++;
      held = 1'b0;
      if (vid_rd) cap_vid_rd++;
      if (aud_rd) cap_aud_rd++;
      if ((vid_rd || aud_rd) && cap_data.size() < 3) rd_err++;
      if (vid_rd && aud_rd) rd_err++;
      if (out_valid && out_ready) begin
        cap_data.push_back(out_data);
        cap_sop.push_back(out_sop);
        cap_eop.push_back(out_eop);
        if (out_eop) done = 1'b1;
      end else if (out_valid) begin
        held = 1'b1;
        held_data = out_data;
      end
    end
    cap_timeout = !done;
    if (done) begin
      @(posedge clk);
      #1;
    end
    out_ready = 1'b0;
  endtask

  // one packet: grant, perturb inputs (after_grant: 0 keep, 1 drop reqs, 2 drop en), check
  task automatic test_packet(input string nm, input bit is_aud, input bit rand_ready,
                             input int after_grant);
    logic [31:0] ts_s;
    bit mk_s, tmo;
    int exp_vrd, exp_ard;
    ts_s = is_aud ? aud_ts : vid_ts;
    mk_s = is_aud ? aud_marker : vid_marker;
    build_exp(is_aud, mk_s, is_aud ? exp_aud_seq : exp_vid_seq, ts_s, is_aud ? aud_idx : vid_idx);
    wait_grant(tmo);
    n_checks++;
    if (tmo) begin
      n_fail++;
      $display("FAIL %s_grant: busy=%0b after 20 cycles, want 1", nm, busy);
    end
    if (after_grant == 1) begin
      vid_req = 1'b0;
      aud_req = 1'b0;
    end else if (after_grant == 2) begin
      en = 1'b0;
    end
    if (is_aud) begin aud_ts = ~ts_s; aud_marker = ~mk_s; end
    else begin vid_ts = ~ts_s; vid_marker = ~mk_s; end
    capture_pkt(rand_ready);
    if (is_aud) begin aud_ts = ts_s; aud_marker = mk_s; end
    else begin vid_ts = ts_s; vid_marker = mk_s; end
    n_checks++;
    if (cap_timeout || cap_data.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL %s_len: got %0d words timeout=%0b, want %0d", nm, cap_data.size(),
               cap_timeout, exp_q.size());
    end
    for (int k = 0; k < exp_q.size() && k < cap_data.size(); k++) begin
      n_checks++;
      if (cap_data[k] !== exp_q[k] || cap_sop[k] !== (k == 0) ||
          cap_eop[k] !== (k == exp_q.size() - 1)) begin
        n_fail++;
        $display("FAIL %s_word%0d: got %h sop=%0b eop=%0b, want %h sop=%0b eop=%0b", nm, k,
                 cap_data[k], cap_sop[k], cap_eop[k], exp_q[k], k == 0, k == exp_q.size() - 1);
      end
    end
    exp_vrd = is_aud ? 0 : int'(VW);
    exp_ard = is_aud ? int'(AW) : 0;
    n_checks++;
    if (cap_vid_rd != exp_vrd || cap_aud_rd != exp_ard || rd_err != 0 || stall_err != 0) begin
      n_fail++;
      $display("FAIL %s_rd: got vid_rd=%0d aud_rd=%0d rd_err=%0d stall_err=%0d, want %0d %0d 0 0",
               nm, cap_vid_rd, cap_aud_rd, rd_err, stall_err, exp_vrd, exp_ard);
    end
    if (is_aud) exp_aud_seq = exp_aud_seq + 16'd1;
    else exp_vid_seq = exp_vid_seq + 16'd1;
    @(negedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_idle_gap: got busy=%0b valid=%0b, want 0 0", nm, busy, out_valid);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; vid_req = 1'b1; aud_req = 1'b1; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if ({out_valid, out_sop, out_eop, vid_rd, aud_rd, busy} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got v/s/e/vrd/ard/busy=%b, want 000000",
               {out_valid, out_sop, out_eop, vid_rd, aud_rd, busy});
    end
    n_checks++;
    if (out_data !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_data: got %h, want 00000000", out_data);
    end
    n_checks++;
    if (dbg_state !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_state: got %0d, want 0", dbg_state);
    end
    aud_req = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic test_video_basic();
    vid_ts = 32'h0000_1234; vid_marker = 1'b1; vid_req = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    test_packet("vid_first", 1'b0, 1'b0, 1);
    n_checks++;
    if (cap_data.size() < 3 || cap_data[0] !== 32'h80E0_0000 || cap_data[1] !== 32'h0000_1234 ||
        cap_data[2] !== 32'h0000_1110) begin
      n_fail++;
      $display("FAIL vid_first_hdr: got %h %h %h, want 80e00000 00001234 00001110",
               cap_data.size() > 0 ? cap_data[0] : 32'hx, cap_data.size() > 1 ? cap_data[1] : 32'hx,
               cap_data.size() > 2 ? cap_data[2] : 32'hx);
    end
    vid_ts = 32'h0000_5678; vid_marker = 1'b0; vid_req = 1'b1;
    test_packet("vid_second", 1'b0, 1'b0, 1);
    n_checks++;
    if (cap_data.size() < 1 || cap_data[0] !== 32'h8060_0001) begin
      n_fail++;
      $display("FAIL vid_second_seq: got %h, want 80600001", cap_data.size() > 0 ? cap_data[0] : 32'hx);
    end
  endtask

  task automatic test_alternation();
    rst_n = 1'b0;
    vid_req = 1'b1; aud_req = 1'b1;
    aud_ts = 32'hAAAA_0001; aud_marker = 1'b0;
    vid_ts = 32'h0BAD_0000; vid_marker = 1'b1;
    repeat (2) @(negedge clk);
    exp_vid_seq = 16'd0; exp_aud_seq = 16'd0;
    rst_n = 1'b1;
    test_packet("alt_aud0", 1'b1, 1'b0, 0);
    n_checks++;
    if (cap_data.size() < 1 || cap_data[0] !== 32'h8061_0000) begin
      n_fail++;
      $display("FAIL alt_first_aud: got %h, want 80610000", cap_data.size() > 0 ? cap_data[0] : 32'hx);
    end
    test_packet("alt_vid0", 1'b0, 1'b0, 0);
    aud_ts = 32'hDEAD_BEEF; aud_marker = 1'b1;
    test_packet("alt_aud1", 1'b1, 1'b0, 1);
    n_checks++;
    if (cap_data.size() < 1 || cap_data[0] !== 32'h80E1_0001) begin
      n_fail++;
      $display("FAIL alt_aud1_hdr: got %h, want 80e10001", cap_data.size() > 0 ? cap_data[0] : 32'hx);
    end
  endtask

  task automatic test_stall();
    vid_ts = 32'h00C0_FFEE; vid_marker = 1'b0; vid_req = 1'b1;
    test_packet("stall_vid", 1'b0, 1'b1, 1);
    aud_ts = 32'h0000_0777; aud_req = 1'b1;
    test_packet("stall_aud", 1'b1, 1'b1, 1);
  endtask

  task automatic test_en();
    bit saw;
    en = 1'b0; vid_req = 1'b1; aud_req = 1'b0; saw = 1'b0;
    repeat (10) begin
      @(negedge clk);
      #1;
      if (busy || out_valid) saw = 1'b1;
    end
    n_checks++;
    if (saw) begin
      n_fail++;
      $display("FAIL en_block: got busy/valid seen=1 with en=0, want 0");
    end
    en = 1'b1;
    test_packet("en_drop", 1'b0, 1'b0, 2);
    saw = 1'b0;
    repeat (6) begin
      @(negedge clk);
      #1;
      if (busy || out_valid) saw = 1'b1;
    end
    n_checks++;
    if (saw) begin
      n_fail++;
      $display("FAIL en_after: got busy/valid seen=1 after en drop, want 0");
    end
    vid_req = 1'b0;
    en = 1'b1;
  endtask

  task automatic test_seq_wrap();
    @(negedge clk);
    force dut.r_vid_seq = 16'hFFFF;
    @(negedge clk);
    release dut.r_vid_seq;
    exp_vid_seq = 16'hFFFF;
    vid_marker = 1'b0; vid_ts = 32'h1111_2222; vid_req = 1'b1;
    test_packet("wrap_ffff", 1'b0, 1'b0, 1);
    n_checks++;
    if (cap_data.size() < 1 || cap_data[0] !== 32'h8060_FFFF) begin
      n_fail++;
      $display("FAIL wrap_ffff_hdr: got %h, want 8060ffff", cap_data.size() > 0 ? cap_data[0] : 32'hx);
    end
    vid_req = 1'b1;
    test_packet("wrap_0000", 1'b0, 1'b0, 1);
    n_checks++;
    if (cap_data.size() < 1 || cap_data[0] !== 32'h8060_0000) begin
      n_fail++;
      $display("FAIL wrap_0000_hdr: got %h, want 80600000", cap_data.size() > 0 ? cap_data[0] : 32'hx);
    end
  endtask

  task automatic test_reset_mid();
    bit tmo;
    vid_req = 1'b1; vid_marker = 1'b0; en = 1'b1;
    wait_grant(tmo);
    n_checks++;
    if (tmo) begin
      n_fail++;
      $display("FAIL rstmid_grant: busy=%0b after 20 cycles, want 1", busy);
    end
    vid_req = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    n_checks++;
    if (dbg_state !== 3'd4 || vid_rd !== 1'b1 || out_eop !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_pay: got state=%0d vid_rd=%0b eop=%0b, want 4 1 0", dbg_state, vid_rd, out_eop);
    end
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    n_checks++;
    if ({out_valid, out_sop, out_eop, vid_rd, aud_rd, busy} !== 6'b0 || out_data !== 32'd0) begin
      n_fail++;
      $display("FAIL rstmid_abort: got v/s/e/vrd/ard/busy=%b data=%h, want 000000 00000000",
               {out_valid, out_sop, out_eop, vid_rd, aud_rd, busy}, out_data);
    end
    out_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_vid_seq = 16'd0; exp_aud_seq = 16'd0;
    vid_req = 1'b1;
    test_packet("rstmid_next", 1'b0, 1'b0, 1);
    n_checks++;
    if (cap_data.size() < 1 || cap_data[0] !== 32'h8060_0000) begin
      n_fail++;
      $display("FAIL rstmid_seq0: got %h, want 80600000", cap_data.size() > 0 ? cap_data[0] : 32'hx);
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; vid_req = 1'b0; aud_req = 1'b0; out_ready = 1'b0;
    vid_ts = '0; aud_ts = '0; vid_marker = 1'b0; aud_marker = 1'b0;
    test_reset();
    test_video_basic();
    test_alternation();
    test_stall();
    test_en();
    test_seq_wrap();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
